// File: rtl/cram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cram_pkg : shared state type and counter-width helper for the loader  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cram_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT    = 3'd2,
    DONE     = 3'd3,
    READBACK = 3'd4
  } loader_state_t;

  // Width able to hold the value n itself (counters that reach their limit).
  function automatic int CRAM_CNT_W(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cram_word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cram_word_serializer : word shift register, one-entry holding buffer |
// | and per-word bit index; emits bit 0 first.  rev 1.0                   |
// +----------------------------------------------------------------------+
module cram_word_serializer
  import cram_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  flush_i,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  output logic                  bit_o,
  output logic                  sr_valid_o,
  output logic                  buf_valid_o
);

  localparam int IDX_W = $clog2(WORD_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);

  logic [WORD_WIDTH-1:0] sr_q, sr_d, buf_q, buf_d;
  logic                  sr_valid_q, sr_valid_d, buf_valid_q, buf_valid_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  always_comb begin
    sr_d        = sr_q;
    buf_d       = buf_q;
    sr_valid_d  = sr_valid_q;
    buf_valid_d = buf_valid_q;
    idx_d       = idx_q;
    if (shift_i) begin
      sr_d  = sr_q >> 1;
      idx_d = idx_q + IDX_W'(1);
      // Refill from the buffer right behind the last bit keeps the stream gap-free.
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
        if (buf_valid_q) begin
          sr_d        = buf_q;
          buf_valid_d = 1'b0;
        end else begin
          sr_valid_d = 1'b0;
        end
      end
    end
    if (load_i) begin
      if (!sr_valid_d) begin
        sr_d       = word_i;
        sr_valid_d = 1'b1;
        idx_d      = '0;
      end else begin
        buf_d       = word_i;
        buf_valid_d = 1'b1;
      end
    end
    if (flush_i) begin
      sr_d        = '0;
      buf_d       = '0;
      sr_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
      idx_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sr_q        <= '0;
      buf_q       <= '0;
      sr_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      sr_q        <= sr_d;
      buf_q       <= buf_d;
      sr_valid_q  <= sr_valid_d;
      buf_valid_q <= buf_valid_d;
      idx_q       <= idx_d;
    end
  end

  assign bit_o       = sr_q[0];
  assign sr_valid_o  = sr_valid_q;
  assign buf_valid_o = buf_valid_q;

endmodule
`default_nettype wire

// File: rtl/cram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cram_loader : streams words into the tile CRAM shift chain, 1 bit/clk |
// | Optional readback path under macro CRAM_READBACK_EN.  rev 1.0         |
// +----------------------------------------------------------------------+
module cram_loader
  import cram_pkg::*;
#(
  parameter int CHAIN_LEN  = 1024,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic                  config_data_in,
  output logic                  config_en,
  input  logic                  config_data_out,
`ifdef CRAM_READBACK_EN
  input  logic                  rb_start,
  output logic                  rb_valid,
  output logic [WORD_WIDTH-1:0] rb_data,
  input  logic                  rb_ready,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W     = CRAM_CNT_W(CHAIN_LEN);
  localparam int NUM_WORDS = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int WC_W      = CRAM_CNT_W(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CHAIN_LEN);
  localparam logic [WC_W-1:0]  ALL_WORDS = WC_W'(NUM_WORDS);

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]  words_q, words_d;
  logic ser_bit, sr_valid, buf_valid;
  logic streaming, accept, load_shift, last_bit, flush, rb_shift, rb_done;

  assign streaming  = en && (state_q == LOAD || state_q == SHIFT);
  // Once every needed word is in, further words are left on the port.
  assign word_ready = streaming && !buf_valid && (words_q != ALL_WORDS);
  assign accept     = word_valid && word_ready;
  assign load_shift = en && (state_q == SHIFT) && sr_valid;
  assign last_bit   = load_shift && (bit_cnt_q == LAST_BIT);
  assign flush      = abort || last_bit;

  cram_word_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_ser (
    .clk        (clk),
    .nrst       (nrst),
    .flush_i    (flush),
    .load_i     (accept),
    .shift_i    (load_shift),
    .word_i     (word_data),
    .bit_o      (ser_bit),
    .sr_valid_o (sr_valid),
    .buf_valid_o(buf_valid)
  );

  assign config_en      = load_shift || rb_shift;
  assign config_data_in = rb_shift ? config_data_out : (load_shift && ser_bit);
  assign busy           = (state_q == LOAD) || (state_q == SHIFT) || (state_q == READBACK);
  assign done           = en && (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    words_d   = words_q;
    if (config_en) bit_cnt_d = bit_cnt_q + CNT_W'(1);
    if (accept)    words_d   = words_q + WC_W'(1);
    case (state_q)
      IDLE: begin
        if (en && start) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
          words_d   = '0;
        end
`ifdef CRAM_READBACK_EN
        else if (en && rb_start) begin
          state_d   = READBACK;
          bit_cnt_d = '0;
        end
`endif
      end
      LOAD:     if (accept) state_d = SHIFT;
      SHIFT: begin
        if (last_bit) state_d = DONE;
        else if (en && !sr_valid && !buf_valid && !accept) state_d = LOAD;
      end
      DONE:     if (en) state_d = IDLE;
      READBACK: if (rb_done) state_d = DONE;
      default:  state_d = IDLE;
    endcase
    // Abort overrides everything, including a held-off enable.
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      words_q   <= words_d;
    end
  end

`ifdef CRAM_READBACK_EN
  localparam int IDX_W = $clog2(WORD_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);

  logic                  rb_valid_q, rb_valid_d;
  logic [WORD_WIDTH-1:0] rb_data_q, rb_data_d, rb_asm_q, rb_asm_d;
  logic [IDX_W-1:0]      rb_idx_q, rb_idx_d;

  // Tail is fed back to the head so the chain content survives the readback.
  assign rb_shift = en && (state_q == READBACK) && (bit_cnt_q != FULL_CNT) && !(rb_valid_q && !rb_ready);
  assign rb_done  = en && (state_q == READBACK) && (bit_cnt_q == FULL_CNT) && rb_valid_q && rb_ready;
  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_data_q;

  always_comb begin
    rb_valid_d = rb_valid_q;
    rb_data_d  = rb_data_q;
    rb_asm_d   = rb_asm_q;
    rb_idx_d   = rb_idx_q;
    if (en && rb_valid_q && rb_ready) rb_valid_d = 1'b0;
    if (rb_shift) begin
      rb_asm_d[rb_idx_q] = config_data_out;
      rb_idx_d = rb_idx_q + IDX_W'(1);
      if (rb_idx_q == LAST_IDX || bit_cnt_q == LAST_BIT) begin
        rb_data_d  = rb_asm_d;
        rb_valid_d = 1'b1;
        rb_asm_d   = '0;
        rb_idx_d   = '0;
      end
    end
    if (abort) begin
      rb_valid_d = 1'b0;
      rb_asm_d   = '0;
      rb_idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
      rb_asm_q   <= '0;
      rb_idx_q   <= '0;
    end else begin
      rb_valid_q <= rb_valid_d;
      rb_data_q  <= rb_data_d;
      rb_asm_q   <= rb_asm_d;
      rb_idx_q   <= rb_idx_d;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = config_data_out;
  assign rb_shift    = 1'b0;
  assign rb_done     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cram_loader : scoreboard bench, randomized word streams vs a       |
// | bit-queue model of the serialized chain.  rev 1.0                     |
// +----------------------------------------------------------------------+
module tb_cram_loader;

  localparam int CL = 72;
  localparam int WW = 32;
  localparam int NW = (CL + WW - 1) / WW;

  logic clk = 1'b0;
  logic nrst, en, start, abort, word_valid, word_ready;
  logic config_data_in, config_en, config_data_out, busy, done;
  logic [WW-1:0] word_data;
  logic [CL-1:0] chain = '0;

  cram_loader #(.CHAIN_LEN(CL), .WORD_WIDTH(WW)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .start          (start),
    .abort          (abort),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .word_data      (word_data),
    .config_data_in (config_data_in),
    .config_en      (config_en),
    .config_data_out(config_data_out),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Behavioural chain: oldest bit ends up at index 0 (the tail).
  always @(posedge clk) if (config_en) chain <= {config_data_in, chain[CL-1:1]};
  assign config_data_out = chain[0];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, shifted = 0, pushed = 0, done_seen = 0, done_cyc = 0;
  int first_en_cyc = 0, last_en_cyc = 0, max_gap = 0, st_cyc = 0;
  logic exp_q[$];
  logic [CL-1:0] img;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected bit stream on every chain shift.
  always @(negedge clk) begin
    if (!en) begin
      chk("en_low_config_en", config_en, 0);
      chk("en_low_word_ready", word_ready, 0);
    end
    if (config_en) begin
      if (exp_q.size() == 0) chk("unexpected_shift", 1, 0);
      else chk("config_bit", config_data_in, exp_q.pop_front());
      if (shifted == 0) first_en_cyc = cyc;
      else if (cyc - last_en_cyc - 1 > max_gap) max_gap = cyc - last_en_cyc - 1;
      last_en_cyc = cyc;
      shifted++;
    end
    if (done) begin
      done_seen++;
      done_cyc = cyc;
      chk("done_bit_count", shifted, CL);
      chk("done_queue_empty", exp_q.size(), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: an accepted word contributes its low bits until CL bits are owed.
  task automatic push_word(input logic [WW-1:0] w);
    for (int b = 0; b < WW; b++) begin
      if (pushed < CL) begin
        exp_q.push_back(w[b]);
        img[pushed] = w[b];
        pushed++;
      end
    end
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int gap, input bit rnd);
    int  guard;
    bit  acc;
    word_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (rnd) begin
        en    = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
      end
      tick();
      start = 1'b0;
    end
    word_valid = 1'b1;
    word_data  = w;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 300) begin
      if (rnd) en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = word_ready;
      tick();
      guard++;
    end
    word_valid = 1'b0;
    en = 1'b1;
    if (acc) push_word(w);
    else chk("accept_timeout", 0, 1);
  endtask

  // mode 0 random, 1 back-to-back timing, 2 mid-stream gap, 3 enable hold
  task automatic do_load(input int mode);
    int d0, guard;
    shifted = 0; pushed = 0; img = '0; max_gap = 0;
    en = 1'b1; start = 1'b1; st_cyc = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (mode == 2 && i == 1) begin
        guard = 0;
        while (shifted < WW && guard < 200) begin tick(); guard++; end
        repeat (4) @(posedge clk);
        #1;
      end
      send_word($urandom(), (mode == 0) ? int'($urandom_range(0, 6)) : 0, mode == 0);
      if (mode == 3 && i == 0) begin
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        chk("en_hold_no_shift", shifted, 0);
      end
    end
    d0 = done_seen;
    word_valid = 1'b1;
    word_data  = $urandom();
    guard = 0;
    while (done_seen == d0 && guard < 300) begin
      @(negedge clk);
      chk("extra_word_ready", word_ready, 0);
      tick();
      guard++;
    end
    word_valid = 1'b0;
    chk("done_pulse_count", done_seen - d0, 1);
    chk("chain_image", chain, img);
    if (mode == 1) begin
      chk("done_latency", done_cyc - st_cyc, CL + 2);
      chk("first_shift_latency", first_en_cyc - st_cyc, 2);
      chk("contiguous_gap", max_gap, 0);
    end
    if (mode == 2) chk("stall_gap_cycles", max_gap, 5);
  endtask

  task automatic do_abort();
    int guard, d0;
    shifted = 0; pushed = 0;
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    send_word($urandom(), 0, 1'b0);
    guard = 0;
    while (shifted < 17 && guard < 200) begin tick(); guard++; end
    if (guard >= 200) chk("abort_wait_timeout", 0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    d0 = done_seen;
    @(negedge clk);
    chk("abort_config_en", config_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_word_ready", word_ready, 0);
    repeat (20) tick();
    chk("abort_no_done", done_seen - d0, 0);
  endtask

  task automatic do_reset_mid();
    int guard;
    shifted = 0; pushed = 0;
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    send_word($urandom(), 0, 1'b0);
    guard = 0;
    while (shifted < 5 && guard < 200) begin tick(); guard++; end
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("arst_word_ready", word_ready, 0);
    chk("arst_config_en", config_en, 0);
    chk("arst_config_data_in", config_data_in, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    tick();
    nrst = 1'b1;
    exp_q.delete();
    tick();
  endtask

  initial begin
    nrst = 1'b0; en = 1'b1; start = 1'b0; abort = 1'b0;
    word_valid = 1'b0; word_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_word_ready", word_ready, 0);
    chk("reset_config_en", config_en, 0);
    chk("reset_config_data_in", config_data_in, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    nrst = 1'b1;
    tick();
    do_load(1);
    do_load(2);
    do_load(3);
    for (int i = 0; i < 12; i++) do_load(0);
    do_abort();
    do_load(0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_beats_start_busy", busy, 0);
    chk("abort_beats_start_ready", word_ready, 0);
    tick();
    do_reset_mid();
    do_load(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
